// File: rtl/joybus_poll_sched_if.sv
// joybus_poll_sched_if
// Bundles the scheduler's bus-facing signals into one interface.
//   slave  : the scheduler side (joybus_poll_sched)
//   master : the glue / tx-rx engine / bench side
// Signals:
//   poll_en, ch_enable        frame timer enable, per-port enable
//   cmd_rdy, cmd_data, ch_sel command strobe to the tx engine, opcode, port mux select
//   rx_done, rx_data          response strobe and word from the rx engine
//   cntlr_data, cntlr_present per-port controller words and presence flags
//   data_valid, data_ch       update strobe and the port it refers to
//   overrun                   sticky frame-overrun flag
//   dbg_state                 scheduler FSM state (IDLE=0, SEL=1, CMD=2, WAIT=3)
//
// Handshake: there is no back-pressure anywhere. cmd_rdy is a single-cycle
// strobe that the tx engine must accept on that cycle; rx_done is a
// single-cycle strobe qualifying rx_data and is only acted on while the
// scheduler is waiting for a response; data_valid is a single-cycle strobe
// qualifying the cntlr_data slice selected by data_ch.
interface joybus_poll_sched_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                 poll_en;
    logic [N_CH-1:0]      ch_enable;
    logic                 cmd_rdy;
    logic [7:0]           cmd_data;
    logic [CH_W-1:0]      ch_sel;
    logic                 rx_done;
    logic [31:0]          rx_data;
    logic [32*N_CH-1:0]   cntlr_data;
    logic [N_CH-1:0]      cntlr_present;
    logic                 data_valid;
    logic [CH_W-1:0]      data_ch;
    logic                 overrun;
    logic [1:0]           dbg_state;

    modport slave (
        input  poll_en, ch_enable, rx_done, rx_data,
        output cmd_rdy, cmd_data, ch_sel, cntlr_data, cntlr_present,
               data_valid, data_ch, overrun, dbg_state
    );

    modport master (
        output poll_en, ch_enable, rx_done, rx_data,
        input  cmd_rdy, cmd_data, ch_sel, cntlr_data, cntlr_present,
               data_valid, data_ch, overrun, dbg_state
    );
endinterface

// File: rtl/joybus_poll_sched.sv
// joybus_poll_sched
// Time-multiplexes one JOYBUS tx/rx engine across N_CH controller ports.
// Once per frame every enabled port gets one command: poll (0x01) if the port
// is present, identify (0x00) otherwise. Responses update the per-port word
// and presence; MISS_LIMIT consecutive timeouts mark a port absent.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : joybus_poll_sched_if.slave (see interface file for signal list)
module joybus_poll_sched #(
    parameter int N_CH           = 4,
    parameter int POLL_CYCLES    = 500000,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int MISS_LIMIT     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    joybus_poll_sched_if.slave   bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IDX_W = $clog2(N_CH + 1);   // idx may reach N_CH (past last port)
    localparam int FC_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(POLL_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      MISS_MAX = 3'(MISS_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, SEL = 2'd1, CMD = 2'd2, WAIT = 2'd3} state_e;

    state_e                  state_q, state_d;
    logic [FC_W-1:0]         frame_q, frame_d;
    logic [TO_W-1:0]         tmo_q, tmo_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pend_q, pend_d;      // frame expired while busy
    logic [CH_W-1:0]         ch_sel_q, ch_sel_d;
    logic                    cmd_rdy_q, cmd_rdy_d;
    logic [7:0]              cmd_data_q, cmd_data_d;
    logic [N_CH-1:0][31:0]   data_q, data_d;
    logic [N_CH-1:0]         present_q, present_d;
    logic [N_CH-1:0][2:0]    miss_q, miss_d;
    logic                    dv_q, dv_d;
    logic [CH_W-1:0]         data_ch_q, data_ch_d;
    logic                    overrun_q, overrun_d;

    logic                    frame_wrap;
    logic                    found;
    logic [CH_W-1:0]         pick;
    logic [2:0]              miss_cur, miss_inc;

    assign frame_wrap = bus.poll_en && (frame_q == FC_LAST);
    assign miss_cur   = miss_q[ch_sel_q];
    assign miss_inc   = (miss_cur >= MISS_MAX) ? MISS_MAX : miss_cur + 3'd1;

    // Lowest enabled port at or above idx; scanning downward lets the last
    // hit be the lowest one.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (bus.ch_enable[j] && (IDX_W'(j) >= idx_q)) begin
                found = 1'b1;
                pick  = CH_W'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        ch_sel_d   = ch_sel_q;
        cmd_rdy_d  = 1'b0;
        cmd_data_d = cmd_data_q;
        data_d     = data_q;
        present_d  = present_q;
        miss_d     = miss_q;
        dv_d       = 1'b0;
        data_ch_d  = data_ch_q;
        overrun_d  = overrun_q;

        // Frame timer runs in every state; an expiry outside IDLE is an
        // overrun and the new frame is deferred until IDLE.
        if (!bus.poll_en) begin
            frame_d = '0;
        end else if (frame_wrap) begin
            frame_d = '0;
        end else begin
            frame_d = frame_q + FC_W'(1);
        end
        if (frame_wrap && (state_q != IDLE)) begin
            overrun_d = 1'b1;
            pend_d    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_wrap || pend_q) begin
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (found) begin
                    ch_sel_d   = pick;
                    cmd_rdy_d  = 1'b1;
                    cmd_data_d = present_q[pick] ? 8'h01 : 8'h00;
                    state_d    = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // rx_done wins over a coincident timeout.
                if (bus.rx_done) begin
                    miss_d[ch_sel_q] = 3'd0;
                    if (present_q[ch_sel_q]) begin
                        data_d[ch_sel_q] = bus.rx_data;
                        dv_d             = 1'b1;
                        data_ch_d        = ch_sel_q;
                    end else begin
                        present_d[ch_sel_q] = 1'b1;
                    end
                    idx_d   = IDX_W'(ch_sel_q) + IDX_W'(1);
                    state_d = SEL;
                end else if (tmo_q == TO_LAST) begin
                    miss_d[ch_sel_q] = miss_inc;
                    if (miss_inc == MISS_MAX) begin
                        present_d[ch_sel_q] = 1'b0;
                        data_d[ch_sel_q]    = 32'h0;
                    end
                    idx_d   = IDX_W'(ch_sel_q) + IDX_W'(1);
                    state_d = SEL;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            ch_sel_q   <= '0;
            cmd_rdy_q  <= 1'b0;
            cmd_data_q <= 8'h00;
            data_q     <= '0;
            present_q  <= '0;
            miss_q     <= '0;
            dv_q       <= 1'b0;
            data_ch_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            ch_sel_q   <= ch_sel_d;
            cmd_rdy_q  <= cmd_rdy_d;
            cmd_data_q <= cmd_data_d;
            data_q     <= data_d;
            present_q  <= present_d;
            miss_q     <= miss_d;
            dv_q       <= dv_d;
            data_ch_q  <= data_ch_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.cmd_rdy       = cmd_rdy_q;
    assign bus.cmd_data      = cmd_data_q;
    assign bus.ch_sel        = ch_sel_q;
    assign bus.cntlr_data    = data_q;
    assign bus.cntlr_present = present_q;
    assign bus.data_valid    = dv_q;
    assign bus.data_ch       = data_ch_q;
    assign bus.overrun       = overrun_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: doc/joybus_poll_sched.md
# joybus_poll_sched

Multi-channel JOYBUS polling scheduler: time-multiplexes one shared JOYBUS tx/rx engine across `N_CH` controller ports and issues a poll command to each port once per frame. Per-channel timeouts detect missing controllers. Disconnected ports are probed with an identify command until they answer. The block sits between the top-level glue and the shared `JOYBUS_tx`/`JOYBUS_rx` pair. Its `ch_sel` output drives the port tristate mux, and per-channel controller words go to button and display logic.

## Interface
- `N_CH`, 4: number of controller ports (2..8).
- `POLL_CYCLES`, 500000: frame period in clk cycles (20 ms @ 25 MHz).
- `TIMEOUT_CYCLES`, 5000: max cycles from cmd issue to `rx_done` (200 µs @ 25 MHz).
- `MISS_LIMIT`, 3: consecutive timeouts before a port is declared absent (1..7).
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `poll_en`  in  1  enables frame timer.
- `ch_enable`  in  N_CH  per-port enable, sampled when that port is selected.
- `cmd_rdy`  out  1  one-cycle pulse to tx engine.
- `cmd_data`  out  8  0x01 (poll) if selected port present, else 0x00 (identify).
- `ch_sel`  out  $clog2(N_CH)  port currently owning tx/rx engine.
- `rx_done`  in  1  one-cycle pulse from rx engine, response complete.
- `rx_data`  in  32  response word; poll: buttons/sticks; identify: ID in [31:8].
- `cntlr_data`  out  32*N_CH  port i data at [32i+31:32i].
- `cntlr_present`  out  N_CH  port answered within last `MISS_LIMIT` attempts.
- `data_valid`  out  1  one-cycle pulse, `cntlr_data` slice updated.
- `data_ch`  out  $clog2(N_CH)  port of last update.
- `overrun`  out  1  sticky: frame period expired while a frame was still running.

## Operation
- States: IDLE, SEL, CMD, WAIT.
- IDLE: frame counter increments while `poll_en`; held at 0 when `poll_en` low.
  - At count == `POLL_CYCLES`-1: counter wraps to 0, `idx` <= 0, go to SEL.
- Frame counter keeps counting during SEL/CMD/WAIT.
  - Expiry outside IDLE sets `overrun` (cleared only by `rst`).
  - The next frame then starts on the first IDLE cycle.
- SEL: pick the lowest index j >= `idx` with `ch_enable[j]`.
  - If found: `ch_sel` <= j, go to CMD.
  - Else: go to IDLE (frame end).
- CMD: `cmd_rdy`=1 for exactly this cycle; `cmd_data` per `cntlr_present[ch_sel]`. Timeout counter <= 0; go to WAIT.
- WAIT: timeout counter increments each cycle.
  - `rx_done` in WAIT: success.
  - Counter reaching `TIMEOUT_CYCLES`-1 without `rx_done`: timeout.
  - `rx_done` and timeout in the same cycle count as success.
  - Either outcome: `idx` <= `ch_sel`+1, go to SEL.
- Success, port present: slice <= `rx_data`; miss count <= 0; `data_valid` pulse; `data_ch` <= `ch_sel`.
- Success, port absent (identify answered): `cntlr_present` <= 1; miss count <= 0; slice unchanged; no `data_valid`.
- Timeout: miss count saturating increment.
  - On reaching `MISS_LIMIT`: `cntlr_present` <= 0 and slice <= 0.
  - Below limit: slice held.
- `rx_done` outside WAIT is ignored.
- Disabled ports are skipped; their present flag, miss count and data are held.
- `rst` at any point: all state, counters and outputs to reset values next edge. No pending command survives.

## Timing
- All outputs registered.
- Reset values: `cmd_rdy`=0, `cmd_data`=0, `ch_sel`=0, `cntlr_data`=0, `cntlr_present`=0, `data_valid`=0, `data_ch`=0, `overrun`=0, state IDLE.
- Frame start: SEL is the cycle after the count hits `POLL_CYCLES`-1; `cmd_rdy` is high the following cycle.
- `ch_sel` is stable from CMD through the last WAIT cycle.
- Success path: the edge sampling `rx_done` high updates the slice, present and miss count. `data_valid`/`data_ch` are high for the following cycle. SEL is the next cycle.
- Timeout: SEL follows `TIMEOUT_CYCLES` cycles after CMD.
- Per-port cost: 2 + response cycles.
- `N_CH`*(`TIMEOUT_CYCLES`+2) must be < `POLL_CYCLES`, else `overrun` is expected.

## Test plan
Bench parameters unless stated: `N_CH`=2, `POLL_CYCLES`=100, `TIMEOUT_CYCLES`=20, `MISS_LIMIT`=2.
- Reset, `poll_en`=1, both enabled, no `rx_done` -> cmd 0x00 on ch0 then ch1 every frame; `cntlr_present`=00, `data_valid` never.
- Ch0 answers identify 10 cycles after cmd, then answers poll with 0x8000_1234 -> `cntlr_present[0]`=1, next frame `cmd_data`=0x01 on ch0. `data_valid` pulse with `data_ch`=0; `cntlr_data[31:0]`=0x8000_1234.
- Present ch0 then times out twice -> after first timeout data held and present=1; after second, present=0, slice=0, next cmd 0x00.
- `ch_enable`=10 -> only ch1 polled, `ch_sel`=1 on every `cmd_rdy`; ch0 state untouched.
- `rx_done` on the exact final timeout cycle -> treated as success. `rx_done` pulsed in IDLE -> no effect.
- `POLL_CYCLES`=30, both ports timing out -> `overrun`=1, held until `rst`. `rst` asserted mid-WAIT -> all outputs reset next edge, no `cmd_rdy` until the next frame.
